fetch_sequencer: RTL and testbench

Core control FSM that fetches 32-bit instruction words from instruction memory and feeds them to the instruction decoder. One fetched word is either one long instruction (bit 31 = 1) or two short 16-bit instructions, issued high half first, then low half. The block drives the decoder enable and half-select, waits for the execution units to finish each instruction, and redirects the PC on taken jumps.

---
 rtl/fetch_sequencer.sv | 108 ++++++++++
 tb/tb_fetch_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Fetches instruction words, issues long or short-pair instructions
//            to the decoder, waits for execution and redirects on jumps.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  halt,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_rd,
  input  logic [WIDTH-1:0]      imem_data,
  input  logic                  imem_valid,
  output logic [WIDTH-1:0]      long_instr,
  output logic                  instr_choose,
  output logic                  dec_en,
  input  logic                  exec_done,
  input  logic                  jump_taken,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  output logic                  busy,
  output logic [WIDTH-1:0]      retired
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_EXEC  = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            w_next;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [WIDTH-1:0]      r_long;
  logic                  r_choose;
  logic                  r_dec_en;
  logic                  r_imem_rd;
  logic                  r_busy;
  logic [WIDTH-1:0]      r_retired;
  logic                  w_word_done;

  // A word is finished once a long instruction or the low half of a pair retires
  assign w_word_done = r_long[WIDTH-1] | r_choose;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start && !halt) w_next = S_FETCH;
      S_FETCH: if (imem_valid) w_next = S_ISSUE;
      S_ISSUE: w_next = S_EXEC;
      S_EXEC: begin
        if (exec_done) begin
          if (halt)                           w_next = S_IDLE;
          else if (jump_taken || w_word_done) w_next = S_FETCH;
          else                                w_next = S_ISSUE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_long    <= '0;
      r_choose  <= 1'b0;
      r_dec_en  <= 1'b0;
      r_imem_rd <= 1'b0;
      r_busy    <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state   <= w_next;
      r_dec_en  <= (w_next == S_ISSUE);
      r_imem_rd <= (w_next == S_FETCH);
      r_busy    <= (w_next != S_IDLE);

      if (r_state == S_FETCH && imem_valid) begin
        r_long   <= imem_data;
        r_choose <= 1'b0;
      end

      if (r_state == S_EXEC && exec_done) begin
        r_retired <= r_retired + {{(WIDTH-1){1'b0}}, 1'b1};
        if (jump_taken)
          r_pc <= jump_target;
        else if (w_word_done)
          r_pc <= r_pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        else
          r_choose <= 1'b1;
      end
    end
  end

  assign imem_addr    = r_pc;
  assign imem_rd      = r_imem_rd;
  assign long_instr   = r_long;
  assign instr_choose = r_choose;
  assign dec_en       = r_dec_en;
  assign busy         = r_busy;
  assign retired      = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Brief    : Scoreboard bench for fetch_sequencer; expected decoder issues are
//            queued as stimulus is driven and matched on every dec_en pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [31:0] imem_data;
  logic        imem_valid;
  logic [31:0] long_instr;
  logic        instr_choose;
  logic        dec_en;
  logic        exec_done, jump_taken;
  logic [15:0] jump_target;
  logic        busy;
  logic [31:0] retired;

  fetch_sequencer #(.WIDTH(32), .ADDR_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
    .imem_valid(imem_valid), .long_instr(long_instr),
    .instr_choose(instr_choose), .dec_en(dec_en), .exec_done(exec_done),
    .jump_taken(jump_taken), .jump_target(jump_target), .busy(busy),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] word;
    logic        choose;
  } exp_t;

  exp_t        r_sb[$];
  exp_t        w_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_retired = 0;
  logic        prev_dec = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && dec_en) begin
      if (prev_dec) chk("dec_en_b2b", 1, 0);
      if (r_sb.size() == 0) begin
        chk("dec_en_unexpected", 1, 0);
      end else begin
        w_e = r_sb.pop_front();
        chk("issue_addr", imem_addr, w_e.addr);
        chk("issue_word", long_instr, w_e.word);
        chk("issue_choose", instr_choose, w_e.choose);
      end
    end
    prev_dec = rst_n && dec_en;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits for the read request, checks the address and returns data after lat cycles
  task automatic fetch_word(input logic [15:0] addr, input logic [31:0] data, input int lat);
    int n = 0;
    while (!imem_rd && n < 20) begin
      tick();
      n++;
    end
    if (!imem_rd) chk("fetch_timeout", 0, 1);
    chk("fetch_addr", imem_addr, addr);
    repeat (lat - 1) tick();
    imem_valid = 1'b1;
    imem_data  = data;
    tick();
    imem_valid = 1'b0;
    imem_data  = 32'hDEAD_BEEF;
  endtask

  task automatic exec_instr(input int dly, input logic jmp, input logic [15:0] tgt, input logic hlt);
    tick();
    halt = hlt;
    repeat (dly) tick();
    exec_done   = 1'b1;
    jump_taken  = jmp;
    jump_target = tgt;
    tick();
    exec_done   = 1'b0;
    jump_taken  = 1'b0;
    jump_target = 16'h0;
    halt        = 1'b0;
    exp_retired = exp_retired + 1;
  endtask

  initial begin
    rst_n = 1'b0; start = 0; halt = 0; imem_data = 0; imem_valid = 0;
    exec_done = 0; jump_taken = 0; jump_target = 0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_dec_en", dec_en, 0);
    chk("rst_imem_rd", imem_rd, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_retired", retired, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // start with halt held must not leave IDLE
    start = 1'b1; halt = 1'b1;
    tick(); tick();
    chk("idle_halt_busy", busy, 0);
    chk("idle_halt_rd", imem_rd, 0);
    start = 1'b0; halt = 1'b0;

    // short pair
    r_sb.push_back('{16'h0, 32'h4A1B_4C2D, 1'b0});
    r_sb.push_back('{16'h0, 32'h4A1B_4C2D, 1'b1});
    do_start();
    chk("busy_fetch", busy, 1);
    fetch_word(16'h0, 32'h4A1B_4C2D, 1);
    exec_instr(1, 0, 0, 0);
    exec_instr(1, 0, 0, 0);
    chk("pair_retired", retired, exp_retired);
    chk("pair_next_addr", imem_addr, 16'h1);
    chk("pair_next_rd", imem_rd, 1);

    // long instruction
    r_sb.push_back('{16'h1, 32'h8C00_1234, 1'b0});
    fetch_word(16'h1, 32'h8C00_1234, 2);
    exec_instr(0, 0, 0, 0);
    chk("long_next_addr", imem_addr, 16'h2);
    chk("long_no_reissue", dec_en, 0);
    chk("long_retired", retired, exp_retired);

    // jump on high half skips the low half
    r_sb.push_back('{16'h2, 32'h1234_5678, 1'b0});
    fetch_word(16'h2, 32'h1234_5678, 1);
    exec_instr(1, 1, 16'h0040, 0);
    chk("jump_addr", imem_addr, 16'h0040);
    chk("jump_rd", imem_rd, 1);
    chk("jump_retired", retired, exp_retired);

    // halt mid-pair, then replay from the high half
    r_sb.push_back('{16'h40, 32'h2222_3333, 1'b0});
    fetch_word(16'h40, 32'h2222_3333, 1);
    exec_instr(2, 0, 0, 1);
    chk("halt_busy", busy, 0);
    chk("halt_addr", imem_addr, 16'h40);
    chk("halt_rd", imem_rd, 0);
    tick(); tick();
    chk("halt_stays_idle", busy, 0);
    chk("halt_retired", retired, exp_retired);
    r_sb.push_back('{16'h40, 32'h2222_3333, 1'b0});
    r_sb.push_back('{16'h40, 32'h2222_3333, 1'b1});
    do_start();
    fetch_word(16'h40, 32'h2222_3333, 1);
    exec_instr(0, 0, 0, 0);
    exec_instr(3, 0, 0, 0);
    chk("replay_next_addr", imem_addr, 16'h41);

    // jump to the top of the address space, then wrap
    r_sb.push_back('{16'h41, 32'h0001_0002, 1'b0});
    fetch_word(16'h41, 32'h0001_0002, 1);
    exec_instr(0, 1, 16'hFFFF, 0);
    r_sb.push_back('{16'hFFFF, 32'h8000_0001, 1'b0});
    fetch_word(16'hFFFF, 32'h8000_0001, 3);
    exec_instr(1, 0, 0, 0);
    chk("wrap_addr", imem_addr, 16'h0000);
    chk("wrap_retired", retired, exp_retired);

    // simultaneous halt and jump
    r_sb.push_back('{16'h0, 32'h9000_0000, 1'b0});
    fetch_word(16'h0, 32'h9000_0000, 1);
    exec_instr(0, 1, 16'h1234, 1);
    chk("hj_addr", imem_addr, 16'h1234);
    chk("hj_busy", busy, 0);
    chk("hj_retired", retired, exp_retired);

    // async reset in FETCH with a late read strobe
    do_start();
    chk("rstf_rd", imem_rd, 1);
    chk("rstf_addr", imem_addr, 16'h1234);
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_rd", imem_rd, 0);
    chk("arst_addr", imem_addr, 0);
    chk("arst_long", long_instr, 0);
    chk("arst_retired", retired, 0);
    exp_retired = 0;
    tick();
    rst_n = 1'b1;
    imem_valid = 1'b1;
    imem_data  = 32'h8765_4321;
    tick(); tick();
    chk("late_valid_dec", dec_en, 0);
    chk("late_valid_busy", busy, 0);
    chk("late_valid_long", long_instr, 0);
    imem_valid = 1'b0;
    tick();

    // normal operation resumes from PC 0
    r_sb.push_back('{16'h0, 32'hC0DE_0001, 1'b0});
    do_start();
    fetch_word(16'h0, 32'hC0DE_0001, 1);
    exec_instr(0, 0, 0, 0);
    chk("resume_addr", imem_addr, 16'h1);
    chk("resume_retired", retired, exp_retired);
    tick();

    chk("sb_empty", r_sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1);
  end

endmodule
`default_nettype wire
